// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and glyph table for the 7-segment display path
package seg7_pkg;

    localparam int SEG_W    = 8;
    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;

    // Active-high segment patterns (bits 6:0 = g..a) for hex digits 0..F
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational active-low segment pattern to hex nibble lookup
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0]          seg_n,
    output logic                hit,
    output logic [NIBBLE_W-1:0] nibble
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = ~seg_n;
        hit    = 1'b0;
        nibble = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg_on == GLYPH_TABLE[i]) begin
                hit    = 1'b1;
                nibble = NIBBLE_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - rebuilds the four displayed hex digits from the muxed display bus
// Optional SEG7_CAPTURE_DP_EN: capture per-digit decimal points into dp_out.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIGITS-1:0]            an_n,
    input  logic [SEG_W-1:0]             seg_n,
    output logic [DIGITS*NIBBLE_W-1:0]   value,
    output logic [DIGITS-1:0]            dig_err,
    output logic [DIGITS-1:0]            dp_out,
    output logic                         frame_valid
);

    localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    logic [DIGITS+SEG_W-1:0]         sample_q, sample_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic                            done_q, done_d;
    logic [DIGITS-1:0]               mask_q, mask_d;
    logic [DIGITS-1:0][NIBBLE_W-1:0] shadow_nib_q, shadow_nib_d;
    logic [DIGITS-1:0]               shadow_err_q, shadow_err_d;
    logic [DIGITS*NIBBLE_W-1:0]      value_q, value_d;
    logic [DIGITS-1:0]               dig_err_q, dig_err_d;
    logic                            frame_valid_q, frame_valid_d;
`ifdef SEG7_CAPTURE_DP_EN
    logic [DIGITS-1:0]               shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]               dp_out_q, dp_out_d;
`endif

    logic                glyph_hit;
    logic [NIBBLE_W-1:0] glyph_nib;
    logic                changed;
    logic                sel_valid;
    logic [1:0]          sel_idx;
    logic                accept;

    seg7_glyph_decode u_decode (
        .seg_n  (seg_n[6:0]),
        .hit    (glyph_hit),
        .nibble (glyph_nib)
    );

    always_comb begin
        sample_d = {an_n, seg_n};
        changed  = (sample_d != sample_q);
        if (changed)
            count_d = CNT_W'(1);
        else if (count_q == CNT_TARGET)
            count_d = count_q;
        else
            count_d = count_q + CNT_W'(1);

        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (an_n)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase

        // A change re-arms the dwell, so the done flag only blocks repeats within one run
        accept = sel_valid && (count_d == CNT_TARGET) && (changed || !done_q);
        done_d = accept ? 1'b1 : (changed ? 1'b0 : done_q);

        mask_d        = mask_q;
        shadow_nib_d  = shadow_nib_q;
        shadow_err_d  = shadow_err_q;
        value_d       = value_q;
        dig_err_d     = dig_err_q;
        frame_valid_d = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
        shadow_dp_d   = shadow_dp_q;
        dp_out_d      = dp_out_q;
`endif

        if (accept) begin
            shadow_nib_d[sel_idx] = glyph_nib;
            shadow_err_d[sel_idx] = ~glyph_hit;
`ifdef SEG7_CAPTURE_DP_EN
            shadow_dp_d[sel_idx]  = ~seg_n[7];
`endif
            mask_d[sel_idx] = 1'b1;
            if (mask_d == '1) begin
                value_d       = shadow_nib_d;
                dig_err_d     = shadow_err_d;
`ifdef SEG7_CAPTURE_DP_EN
                dp_out_d      = shadow_dp_d;
`endif
                mask_d        = '0;
                frame_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q      <= '0;
            count_q       <= '0;
            done_q        <= 1'b0;
            mask_q        <= '0;
            shadow_nib_q  <= '0;
            shadow_err_q  <= '0;
            value_q       <= '0;
            dig_err_q     <= '0;
            frame_valid_q <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
            shadow_dp_q   <= '0;
            dp_out_q      <= '0;
`endif
        end else begin
            sample_q      <= sample_d;
            count_q       <= count_d;
            done_q        <= done_d;
            mask_q        <= mask_d;
            shadow_nib_q  <= shadow_nib_d;
            shadow_err_q  <= shadow_err_d;
            value_q       <= value_d;
            dig_err_q     <= dig_err_d;
            frame_valid_q <= frame_valid_d;
`ifdef SEG7_CAPTURE_DP_EN
            shadow_dp_q   <= shadow_dp_d;
            dp_out_q      <= dp_out_d;
`endif
        end
    end

    assign value       = value_q;
    assign dig_err     = dig_err_q;
    assign frame_valid = frame_valid_q;
`ifdef SEG7_CAPTURE_DP_EN
    assign dp_out      = dp_out_q;
`else
    assign dp_out      = '0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed and random checks of seg7_capture against a run-length model
module tb_seg7_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_n;
    logic [7:0]  seg_n;
    logic [15:0] value;
    logic [3:0]  dig_err;
    logic [3:0]  dp_out;
    logic        frame_valid;

    int checks  = 0;
    int errors  = 0;
    int fv_seen = 0;

    always #5 clk = ~clk;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .value       (value),
        .dig_err     (dig_err),
        .dp_out      (dp_out),
        .frame_valid (frame_valid)
    );

    bit [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    // Model: length of the current run of identical samples, plus captured digit slots
    logic [11:0] m_prev;
    int          m_run;
    logic [3:0]  m_mask;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_err;
    logic [3:0]  m_dp;
    logic [15:0] e_value;
    logic [3:0]  e_err;
    logic [3:0]  e_dp;
    logic        e_fv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_run   = 0;
        m_mask  = '0;
        m_err   = '0;
        m_dp    = '0;
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        e_value = '0;
        e_err   = '0;
        e_dp    = '0;
        e_fv    = 1'b0;
    endtask

    task automatic model_edge();
        logic [11:0] s;
        logic [6:0]  on;
        logic [3:0]  nib;
        logic        hit;
        int          zeros;
        int          k;
        if (rst) begin
            model_reset();
            return;
        end
        s      = {an_n, seg_n};
        m_run  = (s != m_prev) ? 1 : m_run + 1;
        m_prev = s;
        e_fv   = 1'b0;
        zeros  = 0;
        k      = 0;
        for (int i = 0; i < 4; i++) begin
            if (!an_n[i]) begin
                zeros++;
                k = i;
            end
        end
        if (m_run == S && zeros == 1) begin
            on  = ~seg_n[6:0];
            hit = 1'b0;
            nib = '0;
            for (int g = 0; g < 16; g++) begin
                if (glyph[g] == on) begin
                    hit = 1'b1;
                    nib = 4'(g);
                end
            end
            m_nib[k]  = nib;
            m_err[k]  = ~hit;
            m_dp[k]   = ~seg_n[7];
            m_mask[k] = 1'b1;
            if (m_mask == 4'hF) begin
                e_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                e_err   = m_err;
`ifdef SEG7_CAPTURE_DP_EN
                e_dp    = m_dp;
`else
                e_dp    = 4'h0;
`endif
                m_mask  = '0;
                e_fv    = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("value", value, e_value);
        check("dig_err", dig_err, e_err);
        check("dp_out", dp_out, e_dp);
        check("frame_valid", frame_valid, e_fv);
        if (frame_valid) fv_seen++;
    endtask

    task automatic show(input logic [3:0] an, input logic [7:0] seg, input int dwell);
        an_n  = an;
        seg_n = seg;
        rst   = 1'b0;
        repeat (dwell) cycle();
    endtask

    function automatic logic [7:0] enc(input int h, input bit dp);
        logic [6:0] g;
        g = glyph[h];
        return ~{dp, g};
    endfunction

    initial begin
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 8'hFF;
        model_reset();
        cycle();
        cycle();
        check("reset_value", value, 16'h0);
        check("reset_fv", frame_valid, 1'b0);

        // Basic frame 1,2,3,4
        fv_seen = 0;
        show(4'hE, enc(1, 0), 4);
        show(4'hD, enc(2, 0), 4);
        show(4'hB, enc(3, 0), 4);
        show(4'h7, enc(4, 0), 4);
        check("frame1_value", value, 16'h4321);
        check("frame1_err", dig_err, 4'h0);
        check("frame1_fv_count", fv_seen, 1);

        // Dwell one short of the threshold never accepts
        fv_seen = 0;
        show(4'hE, enc(5, 0), 3);
        show(4'hD, enc(6, 0), 3);
        show(4'hB, enc(7, 0), 3);
        show(4'h7, enc(8, 0), 3);
        check("short_dwell_fv", fv_seen, 0);
        check("short_dwell_value", value, 16'h4321);
        show(4'hE, enc(5, 0), 4);
        show(4'hD, enc(6, 0), 4);
        show(4'hB, enc(7, 0), 4);
        show(4'h7, enc(8, 0), 4);
        check("dwell4_value", value, 16'h8765);
        check("dwell4_fv_count", fv_seen, 1);

        // Blank glyph on digit 2
        show(4'hE, enc(9, 0), 4);
        show(4'hD, enc(0, 0), 4);
        show(4'hB, 8'hFF, 4);
        show(4'h7, enc(12, 0), 4);
        check("blank_value", value, 16'hC009);
        check("blank_err", dig_err, 4'b0100);

        // Two digits lit / blanked does not disturb a partial frame
        fv_seen = 0;
        show(4'hE, enc(2, 0), 4);
        show(4'hD, enc(3, 0), 4);
        show(4'hC, enc(7, 0), 20);
        show(4'hF, enc(7, 0), 20);
        check("invalid_an_fv", fv_seen, 0);
        show(4'hB, enc(14, 0), 4);
        show(4'h7, enc(13, 0), 4);
        check("invalid_an_value", value, 16'hDE32);
        check("invalid_an_fv_count", fv_seen, 1);

        // Latest capture of a digit wins
        show(4'hE, enc(10, 0), 4);
        show(4'hD, enc(1, 0), 4);
        show(4'hE, enc(15, 0), 4);
        show(4'hB, enc(2, 0), 4);
        show(4'h7, enc(3, 0), 4);
        check("latest_wins_value", value, 16'h321F);

        // Reset mid-frame discards partial captures
        show(4'hE, enc(5, 0), 4);
        show(4'hD, enc(6, 0), 4);
        show(4'hB, enc(7, 0), 4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midreset_value", value, 16'h0);
        fv_seen = 0;
        show(4'hE, enc(8, 0), 4);
        show(4'hD, enc(9, 1), 4);
        show(4'hB, enc(10, 0), 4);
        check("midreset_partial_fv", fv_seen, 0);
        show(4'h7, enc(11, 0), 4);
        check("midreset_value2", value, 16'hBA98);
        check("midreset_fv_count", fv_seen, 1);
`ifdef SEG7_CAPTURE_DP_EN
        check("dp_digit1", dp_out, 4'b0010);
`else
        check("dp_tied", dp_out, 4'b0000);
`endif

        // Random traffic
        repeat (400) begin
            int r;
            logic [3:0] an;
            logic [7:0] seg;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5, 6: begin
                    case ($urandom_range(0, 3))
                        0: an = 4'hE;
                        1: an = 4'hD;
                        2: an = 4'hB;
                        default: an = 4'h7;
                    endcase
                end
                7: an = 4'hF;
                default: an = 4'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0)
                seg = 8'($urandom);
            else
                seg = enc($urandom_range(0, 15), 1'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                cycle();
            end
            show(an, seg, $urandom_range(1, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
